// File: rtl/or_chk_pkg.sv
// Shared definitions for the OR-gate response checker: FSM state encodings
// and the latency bound used to size the expected-value delay line.
`timescale 1ns/1ps
package or_chk_pkg;

    localparam int MAX_LATENCY = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/or_chk_delay_line.sv
// LATENCY-deep shift register of {valid, a, b, expected} entries. The tail
// lines up each accepted vector with the DUT output sampled LATENCY cycles later.
`timescale 1ns/1ps
module or_chk_delay_line
    import or_chk_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_valid_i,
    input  logic [WIDTH-1:0] push_a_i,
    input  logic [WIDTH-1:0] push_b_i,
    input  logic [WIDTH-1:0] push_exp_i,
    output logic             tail_valid_o,
    output logic [WIDTH-1:0] tail_a_o,
    output logic [WIDTH-1:0] tail_b_o,
    output logic [WIDTH-1:0] tail_exp_o,
    output logic             pending_o
);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] exp;
    } entry_t;

    entry_t stage_q [LATENCY];
    entry_t push_d;

    assign push_d = '{valid: push_valid_i, a: push_a_i, b: push_b_i, exp: push_exp_i};

    // Shifts every cycle; a cycle without a push inserts a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= push_d;
            for (int i = 1; i < LATENCY; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    // Valid entries other than the tail: the line empties on the next shift when clear.
    always_comb begin
        pending_o = 1'b0;
        for (int i = 0; i < LATENCY - 1; i++) begin
            pending_o = pending_o | stage_q[i].valid;
        end
    end

    assign tail_valid_o = stage_q[LATENCY-1].valid;
    assign tail_a_o     = stage_q[LATENCY-1].a;
    assign tail_b_o     = stage_q[LATENCY-1].b;
    assign tail_exp_o   = stage_q[LATENCY-1].exp;

endmodule

// File: rtl/or_gate_response_checker.sv
// Response checker for the OR-gate stimulus path: runs NUM_VECTORS compares of
// DUT output against delayed a|b, keeping saturating statistics and the first failure.
`timescale 1ns/1ps
module or_gate_response_checker
    import or_chk_pkg::*;
#(
    parameter int WIDTH       = 1,
    parameter int LATENCY     = 1,
    parameter int NUM_VECTORS = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             vec_valid,
    input  logic [WIDTH-1:0] vec_a,
    input  logic [WIDTH-1:0] vec_b,
    input  logic [WIDTH-1:0] dut_c,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count,
    output logic             first_fail_valid,
    output logic [WIDTH-1:0] first_fail_a,
    output logic [WIDTH-1:0] first_fail_b,
    output logic [WIDTH-1:0] first_fail_c
);

    localparam int                ACC_W    = $clog2(NUM_VECTORS + 1);
    localparam logic [ACC_W-1:0]  LAST_ACC = ACC_W'(NUM_VECTORS - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic             ff_valid_q, ff_valid_d;
    logic [WIDTH-1:0] ff_a_q, ff_a_d;
    logic [WIDTH-1:0] ff_b_q, ff_b_d;
    logic [WIDTH-1:0] ff_c_q, ff_c_d;
    logic             busy_q, done_q, pass_q;

    logic             accept;
    logic             compare;
    logic             start_run;
    logic             tail_valid;
    logic [WIDTH-1:0] tail_a, tail_b, tail_exp;
    logic             pending;

    assign accept    = (state_q == ST_RUN) && vec_valid;
    assign compare   = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) && tail_valid;
    assign start_run = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    or_chk_delay_line #(
        .WIDTH   (WIDTH),
        .LATENCY (LATENCY)
    ) u_delay (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_valid_i (accept),
        .push_a_i     (vec_a),
        .push_b_i     (vec_b),
        .push_exp_i   (vec_a | vec_b),
        .tail_valid_o (tail_valid),
        .tail_a_o     (tail_a),
        .tail_b_o     (tail_b),
        .tail_exp_o   (tail_exp),
        .pending_o    (pending)
    );

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;
        ff_valid_d = ff_valid_q;
        ff_a_d     = ff_a_q;
        ff_b_d     = ff_b_q;
        ff_c_d     = ff_c_q;

        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN:   if (accept && (acc_q == LAST_ACC)) state_d = ST_DRAIN;
            ST_DRAIN: if (!pending) state_d = ST_DONE;
            ST_DONE:  if (start) state_d = ST_RUN;
            default:  state_d = ST_IDLE;
        endcase

        if (start_run) begin
            acc_d      = '0;
            pass_cnt_d = '0;
            fail_cnt_d = '0;
            ff_valid_d = 1'b0;
            ff_a_d     = '0;
            ff_b_d     = '0;
            ff_c_d     = '0;
        end

        if (accept) begin
            acc_d = acc_q + 1'b1;
        end

        // Counters saturate rather than wrap; only the first mismatch is captured.
        if (compare) begin
            if (dut_c == tail_exp) begin
                if (pass_cnt_q != CNT_MAX) pass_cnt_d = pass_cnt_q + 1'b1;
            end else begin
                if (fail_cnt_q != CNT_MAX) fail_cnt_d = fail_cnt_q + 1'b1;
                if (!ff_valid_q) begin
                    ff_valid_d = 1'b1;
                    ff_a_d     = tail_a;
                    ff_b_d     = tail_b;
                    ff_c_d     = dut_c;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
            ff_valid_q <= 1'b0;
            ff_a_q     <= '0;
            ff_b_q     <= '0;
            ff_c_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
            ff_valid_q <= ff_valid_d;
            ff_a_q     <= ff_a_d;
            ff_b_q     <= ff_b_d;
            ff_c_q     <= ff_c_d;
            busy_q     <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
            done_q     <= (state_d == ST_DONE);
            pass_q     <= (state_d == ST_DONE) && (fail_cnt_d == '0);
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign pass_count       = pass_cnt_q;
    assign fail_count       = fail_cnt_q;
    assign first_fail_valid = ff_valid_q;
    assign first_fail_a     = ff_a_q;
    assign first_fail_b     = ff_b_q;
    assign first_fail_c     = ff_c_q;

endmodule

// File: tb/tb_or_gate_response_checker.sv
// Directed bench for or_gate_response_checker: three instances cover the
// 1-bit latency-1 case, gapped stimulus at latency 3, and a 4-bit faulty DUT.
`timescale 1ns/1ps
module tb_or_gate_response_checker;

    logic clk = 1'b0;
    logic rst_n;
    int   nVectors     = 0;
    int   nMiscompares = 0;

    always #5 clk = ~clk;

    logic       start0, valid0, stuck0;
    logic [0:0] a0, b0, c0, pipe0;
    logic       busy0, done0, pass0, ffv0;
    logic [7:0] pc0, fc0;
    logic [0:0] ffa0, ffb0, ffc0;

    logic       start1, valid1;
    logic [0:0] a1, b1, c1, p1a, p1b, p1c;
    logic       busy1, done1, pass1, ffv1;
    logic [7:0] pc1, fc1;
    logic [0:0] ffa1, ffb1, ffc1;

    logic       start2, valid2;
    logic [3:0] a2, b2, c2, p2a, p2b;
    logic       busy2, done2, pass2, ffv2;
    logic [4:0] pc2, fc2;
    logic [3:0] ffa2, ffb2, ffc2;

    // Behavioural OR gates with matching latency; the stuck-at faults live here.
    always @(posedge clk) pipe0 <= a0 | b0;
    assign c0 = stuck0 ? 1'b0 : pipe0;

    always @(posedge clk) begin
        p1a <= a1 | b1;
        p1b <= p1a;
        p1c <= p1b;
    end
    assign c1 = p1c;

    always @(posedge clk) begin
        p2a <= a2 | b2;
        p2b <= p2a;
    end
    assign c2 = p2b | 4'b0100;

    or_gate_response_checker #(.WIDTH(1), .LATENCY(1), .NUM_VECTORS(4), .CNT_W(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .vec_valid(valid0),
        .vec_a(a0), .vec_b(b0), .dut_c(c0),
        .busy(busy0), .done(done0), .pass(pass0),
        .pass_count(pc0), .fail_count(fc0), .first_fail_valid(ffv0),
        .first_fail_a(ffa0), .first_fail_b(ffb0), .first_fail_c(ffc0)
    );

    or_gate_response_checker #(.WIDTH(1), .LATENCY(3), .NUM_VECTORS(4), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .vec_valid(valid1),
        .vec_a(a1), .vec_b(b1), .dut_c(c1),
        .busy(busy1), .done(done1), .pass(pass1),
        .pass_count(pc1), .fail_count(fc1), .first_fail_valid(ffv1),
        .first_fail_a(ffa1), .first_fail_b(ffb1), .first_fail_c(ffc1)
    );

    or_gate_response_checker #(.WIDTH(4), .LATENCY(2), .NUM_VECTORS(16), .CNT_W(5)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .vec_valid(valid2),
        .vec_a(a2), .vec_b(b2), .dut_c(c2),
        .busy(busy2), .done(done2), .pass(pass2),
        .pass_count(pc2), .fail_count(fc2), .first_fail_valid(ffv2),
        .first_fail_a(ffa2), .first_fail_b(ffb2), .first_fail_c(ffc2)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nVectors++;
        assert (observed === expected) else begin
            nMiscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus0(input logic s, input logic v, input logic a, input logic b);
        start0 = s;
        valid0 = v;
        a0     = a;
        b0     = b;
        tick();
    endtask

    initial begin
        rst_n  = 1'b0;
        start0 = 0; valid0 = 0; a0 = 0; b0 = 0; stuck0 = 0;
        start1 = 0; valid1 = 0; a1 = 0; b1 = 0;
        start2 = 0; valid2 = 0; a2 = 0; b2 = 0;
        #12;
        checkOutput("reset busy", busy0, 0);
        checkOutput("reset done", done0, 0);
        checkOutput("reset pass_count", pc0, 0);
        checkOutput("reset first_fail_valid", ffv0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Ideal DUT, back-to-back vectors at latency 1
        applyStimulus0(1, 0, 0, 0);
        checkOutput("t1 busy in run", busy0, 1);
        applyStimulus0(0, 1, 0, 0);
        applyStimulus0(0, 1, 0, 1);
        checkOutput("t1 pass_count after first compare", pc0, 1);
        applyStimulus0(0, 1, 1, 0);
        applyStimulus0(0, 1, 1, 1);
        checkOutput("t1 done during drain", done0, 0);
        checkOutput("t1 busy during drain", busy0, 1);
        applyStimulus0(0, 0, 0, 0);
        checkOutput("t1 done", done0, 1);
        checkOutput("t1 pass", pass0, 1);
        checkOutput("t1 pass_count", pc0, 4);
        checkOutput("t1 fail_count", fc0, 0);
        checkOutput("t1 first_fail_valid", ffv0, 0);
        checkOutput("t1 busy after done", busy0, 0);

        // Stuck-at-0 DUT, started from DONE
        stuck0 = 1'b1;
        applyStimulus0(1, 0, 0, 0);
        checkOutput("t2 start clears done", done0, 0);
        checkOutput("t2 start clears pass_count", pc0, 0);
        applyStimulus0(0, 1, 0, 0);
        applyStimulus0(0, 1, 0, 1);
        applyStimulus0(0, 1, 1, 0);
        applyStimulus0(0, 1, 1, 1);
        applyStimulus0(0, 0, 0, 0);
        checkOutput("t2 done", done0, 1);
        checkOutput("t2 pass", pass0, 0);
        checkOutput("t2 pass_count", pc0, 1);
        checkOutput("t2 fail_count", fc0, 3);
        checkOutput("t2 first_fail_valid", ffv0, 1);
        checkOutput("t2 first_fail_a", ffa0, 0);
        checkOutput("t2 first_fail_b", ffb0, 1);
        checkOutput("t2 first_fail_c", ffc0, 0);
        applyStimulus0(0, 1, 1, 1);
        applyStimulus0(0, 1, 1, 1);
        checkOutput("t2 vec_valid in done pass_count", pc0, 1);
        checkOutput("t2 vec_valid in done fail_count", fc0, 3);
        checkOutput("t2 done holds", done0, 1);

        // Start with vec_valid, start during RUN
        stuck0 = 1'b0;
        applyStimulus0(1, 1, 1, 1);
        checkOutput("t3 first_fail cleared", ffv0, 0);
        applyStimulus0(0, 1, 0, 0);
        applyStimulus0(1, 1, 0, 1);
        applyStimulus0(0, 1, 1, 0);
        checkOutput("t3 start in run ignored", pc0, 2);
        applyStimulus0(0, 0, 0, 0);
        applyStimulus0(0, 0, 0, 0);
        applyStimulus0(0, 0, 0, 0);
        checkOutput("t3 still busy after 3 accepts", busy0, 1);
        checkOutput("t3 not done after 3 accepts", done0, 0);
        checkOutput("t3 pass_count after gap", pc0, 3);
        applyStimulus0(0, 1, 1, 1);
        applyStimulus0(0, 0, 0, 0);
        checkOutput("t3 done", done0, 1);
        checkOutput("t3 pass_count", pc0, 4);
        checkOutput("t3 fail_count", fc0, 0);

        // Reset mid-run
        applyStimulus0(1, 0, 0, 0);
        applyStimulus0(0, 1, 0, 1);
        applyStimulus0(0, 1, 1, 1);
        valid0 = 1'b0;
        checkOutput("t4 pass_count before reset", pc0, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t4 async reset pass_count", pc0, 0);
        checkOutput("t4 async reset busy", busy0, 0);
        checkOutput("t4 async reset done", done0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus0(1, 0, 0, 0);
        applyStimulus0(0, 1, 0, 0);
        applyStimulus0(0, 1, 1, 1);
        applyStimulus0(0, 1, 0, 1);
        applyStimulus0(0, 1, 1, 1);
        applyStimulus0(0, 0, 0, 0);
        checkOutput("t4 rerun done", done0, 1);
        checkOutput("t4 rerun pass_count", pc0, 4);

        // Gapped stimulus at latency 3
        start1 = 1; tick(); start1 = 0;
        valid1 = 1; a1 = 1; b1 = 1; tick();
        valid1 = 0; tick(); tick();
        valid1 = 1; a1 = 0; b1 = 0; tick();
        a1 = 1; b1 = 0; tick();
        checkOutput("t5 pass_count after one compare", pc1, 1);
        valid1 = 0; tick();
        valid1 = 1; a1 = 0; b1 = 1; tick();
        valid1 = 0;
        checkOutput("t5 pass_count entering drain", pc1, 2);
        checkOutput("t5 busy in drain", busy1, 1);
        tick();
        checkOutput("t5 pass_count drain 1", pc1, 3);
        tick();
        checkOutput("t5 bubble not compared", pc1, 3);
        checkOutput("t5 not done after 2 drain cycles", done1, 0);
        tick();
        checkOutput("t5 done after 3 drain cycles", done1, 1);
        checkOutput("t5 pass_count", pc1, 4);
        checkOutput("t5 fail_count", fc1, 0);
        checkOutput("t5 pass", pass1, 1);

        // 4-bit DUT with bit2 stuck-at-1; b=~a expects all ones so it stays hidden
        start2 = 1; tick(); start2 = 0;
        valid2 = 1;
        for (int i = 0; i < 16; i++) begin
            a2 = 4'(i);
            b2 = ~4'(i);
            tick();
        end
        valid2 = 0;
        tick();
        checkOutput("t6 not done one cycle after last", done2, 0);
        tick();
        checkOutput("t6 done complement sweep", done2, 1);
        checkOutput("t6 pass_count complement sweep", pc2, 16);
        checkOutput("t6 fail_count complement sweep", fc2, 0);

        // Same DUT with b=0: every a with bit2 clear must fail
        start2 = 1; tick(); start2 = 0;
        valid2 = 1;
        for (int i = 0; i < 16; i++) begin
            a2 = 4'(i);
            b2 = 4'h0;
            tick();
        end
        valid2 = 0;
        tick(); tick();
        checkOutput("t6 done zero-b sweep", done2, 1);
        checkOutput("t6 pass_count zero-b sweep", pc2, 8);
        checkOutput("t6 fail_count zero-b sweep", fc2, 8);
        checkOutput("t6 pass zero-b sweep", pass2, 0);
        checkOutput("t6 first_fail_valid", ffv2, 1);
        checkOutput("t6 first_fail_a", ffa2, 4'h0);
        checkOutput("t6 first_fail_b", ffb2, 4'h0);
        checkOutput("t6 first_fail_c", ffc2, 4'h4);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
